// File: rtl/ip_pkg.sv
// Shared IPv4 receive constants: header field offsets, protocol numbers and FSM states.
package ip_pkg;
  localparam logic [3:0] IPV4_VER     = 4'd4;
  localparam logic [3:0] IPV4_IHL_MIN = 4'd5;
  localparam int         IPV4_HDR_N   = 20;
  localparam int         PROTO_UDP    = 17;

  localparam int OFF_VIHL  = 0;
  localparam int OFF_TLEN  = 2;
  localparam int OFF_FRAG  = 6;
  localparam int OFF_PROTO = 9;
  localparam int OFF_SRC   = 12;
  localparam int OFF_DST   = 16;

  typedef enum logic [1:0] {IDLE, HEAD, DATA, DROP} state_t;
endpackage

// File: rtl/ip_csum.sv
// Ones-complement accumulator over IPv4 header bytes; each byte is weighted by its offset
// parity, so 16b words split across beats need no realignment.
module ip_csum #(
  parameter int NB = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          valid,
  input  logic [NB*8-1:0] data,
  input  logic [NB-1:0] be,
  input  logic [NB-1:0] hi,
  output logic          ok_o
);
  logic [15:0] acc, sum;
  logic [18:0] tot;
  logic [16:0] f1;

  always_comb begin
    tot = start ? 19'd0 : {3'd0, acc};
    for (int k = 0; k < NB; k++)
      if (be[k]) tot = tot + (hi[k] ? {3'd0, data[8*k +: 8], 8'd0} : {11'd0, data[8*k +: 8]});
    // two folds always suffice: at most five 16b terms per beat
    f1  = {1'b0, tot[15:0]} + {14'd0, tot[18:16]};
    sum = f1[15:0] + {15'd0, f1[16]};
  end

  assign ok_o = (sum == 16'hFFFF);

  always_ff @(posedge clk or posedge reset)
    if (reset)      acc <= '0;
    else if (valid) acc <= sum;
endmodule

// File: rtl/ipv4_rx.sv
// IPv4 receive stage: parses/validates the 20-byte header, drops bad packets and forwards the
// payload trimmed to total_length, one registered cycle behind the MAC stream.
module ipv4_rx import ip_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int PROTO   = PROTO_UDP,
  parameter bit CHK_DST = 1'b1,
  localparam int NB     = DATA_W/8,
  localparam int LEN_W  = $clog2(DATA_W/8+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ip_addr_i,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              crc_err_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [31:0]       src_addr_o,
  output logic              hdr_err_o,
  output logic              crc_err_o
);
  localparam logic [7:0]  PROTO_B = 8'(PROTO);
  localparam logic [15:0] HDR_N   = 16'(IPV4_HDR_N);

  state_t state, state_n;
  logic [15:0] byte_cnt, byte_cnt_n, rem, rem_n;
  logic        need_start, need_start_n;
  logic [7:0]  hdr_q [IPV4_HDR_N];
  logic [7:0]  hdr_n [IPV4_HDR_N];
  logic [15:0] off   [NB];
  logic [NB-1:0] be, hi;
  logic        eff, hd_beat, hdr_done, chk_ok, csum_ok;
  logic [15:0] base, end_cnt, surplus, hb, tl_n, pay;
  logic [31:0] src_n, dst_n;
  logic        v_n, s_n, l_n, e_n;
  logic [DATA_W-1:0] d_n;
  logic [LEN_W-1:0]  len_n;

  assign eff     = valid_i && (len_i != '0);
  assign hd_beat = eff && (start_i || state == HEAD);
  assign base    = start_i ? 16'd0 : byte_cnt;
  assign end_cnt = base + 16'(len_i);

  // place this beat's header bytes into the capture array by absolute offset
  always_comb begin
    hdr_n = hdr_q;
    for (int k = 0; k < NB; k++) begin
      off[k] = base + 16'(k);
      be[k]  = hd_beat && (LEN_W'(k) < len_i) && (off[k] < HDR_N);
      hi[k]  = ~off[k][0];
      if (be[k]) hdr_n[off[k][4:0]] = data_i[8*k +: 8];
    end
  end

  ip_csum #(.NB(NB)) u_csum (
    .clk(clk), .reset(reset), .start(start_i), .valid(hd_beat),
    .data(data_i), .be(be), .hi(hi), .ok_o(csum_ok)
  );

  assign tl_n     = {hdr_n[OFF_TLEN], hdr_n[OFF_TLEN+1]};
  assign src_n    = {hdr_n[OFF_SRC], hdr_n[OFF_SRC+1], hdr_n[OFF_SRC+2], hdr_n[OFF_SRC+3]};
  assign dst_n    = {hdr_n[OFF_DST], hdr_n[OFF_DST+1], hdr_n[OFF_DST+2], hdr_n[OFF_DST+3]};
  assign hdr_done = hd_beat && (end_cnt >= HDR_N);
  assign surplus  = end_cnt - HDR_N;
  assign hb       = HDR_N - base;
  assign pay      = tl_n - HDR_N;

  // MF is bit 5 of byte 6; fragment offset spans byte6[4:0] and byte 7
  assign chk_ok = (hdr_n[OFF_VIHL] == {IPV4_VER, IPV4_IHL_MIN}) && !hdr_n[OFF_FRAG][5] &&
                  ({hdr_n[OFF_FRAG][4:0], hdr_n[OFF_FRAG+1]} == 13'd0) &&
                  (hdr_n[OFF_PROTO] == PROTO_B) && (tl_n >= HDR_N) && csum_ok &&
                  (!CHK_DST || dst_n == ip_addr_i);

  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    rem_n        = rem;
    need_start_n = need_start;
    v_n = 1'b0; s_n = 1'b0; l_n = 1'b0; e_n = 1'b0;
    d_n   = '0;
    len_n = '0;
    if (cancel_i) begin
      state_n = IDLE;
    end else if (hd_beat) begin
      byte_cnt_n = end_cnt;
      state_n    = HEAD;
      if (hdr_done) begin
        if (!chk_ok) begin
          e_n     = 1'b1;
          state_n = DROP;
        end else if (tl_n == HDR_N) begin
          state_n = IDLE;
        end else if (surplus != 16'd0) begin
          v_n = 1'b1;
          s_n = 1'b1;
          d_n = data_i >> (hb * 16'd8);
          if (surplus >= pay) begin
            len_n   = LEN_W'(pay);
            l_n     = 1'b1;
            state_n = IDLE;
          end else begin
            len_n        = LEN_W'(surplus);
            rem_n        = pay - surplus;
            need_start_n = 1'b0;
            state_n      = DATA;
          end
        end else begin
          rem_n        = pay;
          need_start_n = 1'b1;
          state_n      = DATA;
        end
      end
    end else if (eff && state == DATA) begin
      v_n          = 1'b1;
      s_n          = need_start;
      need_start_n = 1'b0;
      d_n          = data_i;
      if (16'(len_i) >= rem) begin
        len_n   = LEN_W'(rem);
        l_n     = 1'b1;
        state_n = IDLE;
      end else begin
        len_n = len_i;
        rem_n = rem - 16'(len_i);
      end
    end
    for (int k = 0; k < NB; k++)
      if (LEN_W'(k) >= len_n) d_n[8*k +: 8] = 8'd0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      rem        <= '0;
      need_start <= 1'b0;
      for (int i = 0; i < IPV4_HDR_N; i++) hdr_q[i] <= '0;
      valid_o    <= 1'b0;
      start_o    <= 1'b0;
      last_o     <= 1'b0;
      data_o     <= '0;
      len_o      <= '0;
      src_addr_o <= '0;
      hdr_err_o  <= 1'b0;
      crc_err_o  <= 1'b0;
    end else begin
      byte_cnt   <= byte_cnt_n;
      rem        <= rem_n;
      need_start <= need_start_n;
      if (hd_beat) hdr_q <= hdr_n;
      valid_o    <= v_n;
      start_o    <= s_n;
      last_o     <= l_n;
      data_o     <= d_n;
      len_o      <= len_n;
      if (s_n) src_addr_o <= src_n;
      hdr_err_o  <= e_n;
      crc_err_o  <= crc_err_i;
    end
  end
endmodule

// File: tb/tb_ipv4_rx.sv
// Bench for ipv4_rx: 16b and 32b instances, byte-level packet model predicting payload beats.
module tb_ipv4_rx;
  localparam logic [31:0] IP  = 32'hC0A8_0001;
  localparam logic [31:0] SRC = 32'h0A00_0002;

  typedef struct { logic s; logic l; int len; logic [31:0] d; logic [31:0] src; } ob_t;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic c16, v16, s16, e16; logic [15:0] d16; logic [1:0] l16;
  logic c32, v32, s32, e32; logic [31:0] d32; logic [2:0] l32;
  logic ov16, os16, ol16, oh16, oc16; logic [15:0] od16; logic [1:0] olen16; logic [31:0] osrc16;
  logic ov32, os32, ol32, oh32, oc32; logic [31:0] od32; logic [2:0] olen32; logic [31:0] osrc32;

  ipv4_rx #(.DATA_W(16)) u16 (
    .clk(clk), .reset(reset), .ip_addr_i(IP), .cancel_i(c16), .valid_i(v16), .start_i(s16),
    .data_i(d16), .len_i(l16), .crc_err_i(e16), .valid_o(ov16), .start_o(os16), .last_o(ol16),
    .data_o(od16), .len_o(olen16), .src_addr_o(osrc16), .hdr_err_o(oh16), .crc_err_o(oc16));

  ipv4_rx #(.DATA_W(32)) u32 (
    .clk(clk), .reset(reset), .ip_addr_i(IP), .cancel_i(c32), .valid_i(v32), .start_i(s32),
    .data_i(d32), .len_i(l32), .crc_err_i(e32), .valid_o(ov32), .start_o(os32), .last_o(ol32),
    .data_o(od32), .len_o(olen32), .src_addr_o(osrc32), .hdr_err_o(oh32), .crc_err_o(oc32));

  int tests = 0, fails = 0;
  logic [7:0] pkt[$];
  int lens[$];
  ob_t mq[$], q16[$], q32[$];
  ob_t e16b, e32b;
  int merr;
  int eerr16 = 0, eerr32 = 0, ecrc16 = 0, ecrc32 = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic cmp_beat(string nm, ob_t e, logic s, logic l, int len, logic [31:0] d, logic [31:0] src);
    logic [31:0] m;
    m = (len >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*len)) - 32'd1);
    chk({nm, "_start"}, s, e.s);
    chk({nm, "_last"}, l, e.l);
    chk({nm, "_len"}, len, e.len);
    chk({nm, "_data"}, d & m, e.d & m);
    if (e.s) chk({nm, "_src"}, src, e.src);
  endtask

  always @(negedge clk) if (!reset) begin
    if (ov16) begin
      if (q16.size() == 0) chk("u16_unexpected_beat", ov16, 1'b0);
      else begin e16b = q16.pop_front(); cmp_beat("u16", e16b, os16, ol16, int'(olen16), {16'h0, od16}, osrc16); end
    end
    if (oh16) begin if (eerr16 == 0) chk("u16_unexpected_hdr_err", oh16, 1'b0); else eerr16--; end
    if (oc16) begin if (ecrc16 == 0) chk("u16_unexpected_crc_err", oc16, 1'b0); else ecrc16--; end
    if (ov32) begin
      if (q32.size() == 0) chk("u32_unexpected_beat", ov32, 1'b0);
      else begin e32b = q32.pop_front(); cmp_beat("u32", e32b, os32, ol32, int'(olen32), od32, osrc32); end
    end
    if (oh32) begin if (eerr32 == 0) chk("u32_unexpected_hdr_err", oh32, 1'b0); else eerr32--; end
    if (oc32) begin if (ecrc32 == 0) chk("u32_unexpected_crc_err", oc32, 1'b0); else ecrc32--; end
  end

  // header with a correct checksum, then payload 1..npay, then zero padding up to pad_to
  task automatic make_pkt(input int tl, input int proto, input logic [7:0] vihl, input logic [7:0] f6,
                          input logic [31:0] dst, input int npay, input int pad_to);
    logic [7:0] h[20];
    logic [31:0] s;
    int sum;
    s = SRC;
    for (int i = 0; i < 20; i++) h[i] = 8'h00;
    h[0] = vihl; h[2] = tl[15:8]; h[3] = tl[7:0]; h[6] = f6; h[8] = 8'd64; h[9] = proto[7:0];
    for (int i = 0; i < 4; i++) begin
      h[12+i] = s[31-8*i -: 8];
      h[16+i] = dst[31-8*i -: 8];
    end
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'({h[2*i], h[2*i+1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = ~sum & 32'hFFFF;
    h[10] = sum[15:8]; h[11] = sum[7:0];
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(h[i]);
    for (int i = 0; i < npay; i++) pkt.push_back(8'(i + 1));
    while (pkt.size() < pad_to) pkt.push_back(8'h00);
  endtask

  // expected payload beats: the slice of each input beat that falls in bytes [20, total_length)
  task automatic model(input int cancel_at);
    int tl, sum, pos, lo, hi, p;
    bit ok, first;
    ob_t o;
    mq.delete(); merr = 0;
    tl = int'({pkt[2], pkt[3]});
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'({pkt[2*i], pkt[2*i+1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ok = (pkt[0] == 8'h45) && (pkt[6][5] == 1'b0) && ({pkt[6][4:0], pkt[7]} == 13'd0) &&
         (pkt[9] == 8'd17) && (tl >= 20) && (sum == 32'hFFFF) &&
         ({pkt[16], pkt[17], pkt[18], pkt[19]} == IP);
    if (!ok) begin merr = 1; return; end
    p = tl - 20; pos = 0; first = 1'b1;
    for (int b = 0; b < lens.size(); b++) begin
      if (b == cancel_at) break;
      lo = (pos > 20) ? pos : 20;
      hi = (pos + lens[b] < 20 + p) ? pos + lens[b] : 20 + p;
      if (hi > lo) begin
        o.s = first; o.l = (hi == 20 + p); o.len = hi - lo; o.d = '0;
        o.src = {pkt[12], pkt[13], pkt[14], pkt[15]};
        for (int j = lo; j < hi; j++) o.d[8*(j-lo) +: 8] = pkt[j];
        mq.push_back(o);
        first = 1'b0;
      end
      pos += lens[b];
    end
  endtask

  task automatic idle();
    c16 = 0; v16 = 0; s16 = 0; e16 = 0; d16 = '0; l16 = '0;
    c32 = 0; v32 = 0; s32 = 0; e32 = 0; d32 = '0; l32 = '0;
  endtask

  task automatic set_in(input int which, input bit c, input bit v, input bit s, input logic [31:0] d,
                        input int len, input bit e);
    if (which == 0) begin c16 = c; v16 = v; s16 = s; d16 = d[15:0]; l16 = len[1:0]; e16 = e; end
    else            begin c32 = c; v32 = v; s32 = s; d32 = d;       l32 = len[2:0]; e32 = e; end
  endtask

  task automatic send(input int which, input int first_len, input int cancel_at, input bit crc);
    int nb, pos, n;
    logic [31:0] d;
    nb = (which != 0) ? 4 : 2;
    lens.delete(); pos = 0;
    n = (first_len != 0) ? first_len : nb;
    while (pos < pkt.size()) begin
      if (n > pkt.size() - pos) n = pkt.size() - pos;
      lens.push_back(n); pos += n; n = nb;
    end
    model(cancel_at);
    foreach (mq[i]) if (which == 0) q16.push_back(mq[i]); else q32.push_back(mq[i]);
    if (which == 0) begin eerr16 += merr; ecrc16 += int'(crc); end
    else            begin eerr32 += merr; ecrc32 += int'(crc); end
    pos = 0;
    for (int b = 0; b < lens.size(); b++) begin
      if (b == cancel_at) begin
        set_in(which, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        @(posedge clk); #1;
      end
      d = '0;
      for (int j = 0; j < lens[b]; j++) d[8*j +: 8] = pkt[pos+j];
      set_in(which, 1'b0, 1'b1, b == 0, d, lens[b], crc && (b == lens.size() - 1));
      @(posedge clk); #1;
      pos += lens[b];
    end
    idle();
  endtask

  task automatic drain(string nm);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_q16_empty"}, q16.size(), 0);
    chk({nm, "_q32_empty"}, q32.size(), 0);
    chk({nm, "_err16_seen"}, eerr16, 0);
    chk({nm, "_err32_seen"}, eerr32, 0);
    chk({nm, "_crc_seen"}, ecrc16 + ecrc32, 0);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid16", ov16, 1'b0);
    chk("rst_src16", osrc16, 32'h0);
    chk("rst_err16", oh16, 1'b0);
    chk("rst_valid32", ov32, 1'b0);
    chk("rst_data32", od32, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic 28-byte packet, 8 payload bytes
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 0);
    send(0, 0, -1, 1'b0);
    chk("pin_t1_beats", mq.size(), 4);
    chk("pin_t1_first_data", mq[0].d, 32'h0000_0201);
    chk("pin_t1_first_start", mq[0].s, 1'b1);
    chk("pin_t1_last_flag", mq[3].l, 1'b1);
    chk("pin_t1_last_data", mq[3].d, 32'h0000_0807);
    drain("t1");

    // padded to Ethernet minimum
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 46);
    send(0, 0, -1, 1'b0);
    chk("pin_t2_beats", mq.size(), 4);
    drain("t2");

    // corrupted checksum, then a good packet
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 0);
    pkt[10] = pkt[10] ^ 8'h01;
    send(0, 0, -1, 1'b0);
    chk("pin_t3_err", merr, 1);
    chk("pin_t3_beats", mq.size(), 0);
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 0);
    send(0, 0, -1, 1'b0);
    drain("t3");

    // individual header faults
    make_pkt(28, 6,  8'h45, 8'h00, IP, 8, 0);          send(0, 0, -1, 1'b0);
    make_pkt(28, 17, 8'h46, 8'h00, IP, 8, 0);          send(0, 0, -1, 1'b0);
    make_pkt(28, 17, 8'h65, 8'h00, IP, 8, 0);          send(0, 0, -1, 1'b0);
    make_pkt(28, 17, 8'h45, 8'h20, IP, 8, 0);          send(0, 0, -1, 1'b0);
    make_pkt(28, 17, 8'h45, 8'h01, IP, 8, 0);          send(0, 0, -1, 1'b0);
    make_pkt(28, 17, 8'h45, 8'h00, IP + 32'd1, 8, 0);  send(0, 0, -1, 1'b0);
    make_pkt(18, 17, 8'h45, 8'h00, IP, 8, 0);          send(0, 0, -1, 1'b0);
    drain("t4");

    // 32b datapath: header ends mid-beat after a 2-byte first beat
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 0);
    send(1, 2, -1, 1'b0);
    chk("pin_t5_first_len", mq[0].len, 2);
    chk("pin_t5_first_data", mq[0].d, 32'h0000_0201);
    chk("pin_t5_beats", mq.size(), 3);
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 46);  send(1, 0, -1, 1'b0);
    make_pkt(31, 17, 8'h45, 8'h00, IP, 11, 46); send(1, 3, -1, 1'b0);
    make_pkt(28, 6,  8'h45, 8'h00, IP, 8, 0);   send(1, 0, -1, 1'b0);
    drain("t5");

    // cancel mid-payload; the rest of that packet must be ignored
    make_pkt(40, 17, 8'h45, 8'h00, IP, 20, 0);
    send(0, 0, 12, 1'b0);
    chk("pin_t6_beats", mq.size(), 2);
    chk("pin_t6_no_last", mq[1].l, 1'b0);
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 0);
    send(0, 0, -1, 1'b0);
    drain("t6");

    // header-only packet, CRC flag forwarding, odd byte alignment, truncated packet
    make_pkt(20, 17, 8'h45, 8'h00, IP, 0, 46);
    send(0, 0, -1, 1'b0);
    chk("pin_t7_beats", mq.size(), 0);
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 46);  send(0, 0, -1, 1'b1);
    make_pkt(28, 17, 8'h45, 8'h00, IP, 8, 0);   send(0, 1, -1, 1'b0);
    make_pkt(40, 17, 8'h45, 8'h00, IP, 20, 0);
    while (pkt.size() > 30) void'(pkt.pop_back());
    send(0, 0, -1, 1'b0);
    make_pkt(29, 17, 8'h45, 8'h00, IP, 9, 0);   send(0, 0, -1, 1'b0);
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
